// File: rtl/q88_mac_neuron.sv
// Single Q8.8 neuron: bias + dot product over VEC_LEN pairs, saturated to Q8.8,
// then optional ReLU / leaky ReLU. Stream in pairs, hand one result downstream.
module q88_mac_neuron #(
  parameter int VEC_LEN     = 8,
  parameter int ACC_W       = 40,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] bias,
  input  logic [1:0]         act_sel,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_x,
  input  logic signed [15:0] in_w,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_y,
  output logic               out_sat
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
  localparam logic signed [ACC_W-1:0] T_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] T_MIN = -ACC_W'(32768);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EXTRACT,
    S_OUTPUT
  } state_t;

  state_t                   state_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [CNT_W-1:0]         count_reg;
  logic [1:0]               act_reg;
  logic                     busy_reg;
  logic                     in_ready_reg;
  logic                     out_valid_reg;
  logic signed [15:0]       out_y_reg;
  logic                     out_sat_reg;

  logic signed [31:0]       product;
  logic signed [ACC_W-1:0]  bias_aligned;
  logic signed [ACC_W-1:0]  t_full;
  logic signed [15:0]       sat_t;
  logic                     sat_flag;
  logic signed [15:0]       act_y;

  assign product      = in_x * in_w;
  // Q8.8 bias moved into the Q16.16 domain of the products.
  assign bias_aligned = {{(ACC_W-16){bias[15]}}, bias} <<< 8;
  assign t_full       = acc_reg >>> 8;

  always_comb begin
    sat_flag = 1'b0;
    sat_t    = t_full[15:0];
    if (t_full > T_MAX) begin
      sat_t    = 16'sh7FFF;
      sat_flag = 1'b1;
    end else if (t_full < T_MIN) begin
      sat_t    = 16'sh8000;
      sat_flag = 1'b1;
    end

    act_y = sat_t;
    if (sat_t[15]) begin
      case (act_reg)
        2'd1:    act_y = 16'sh0000;
        2'd2:    act_y = sat_t >>> LEAKY_SHIFT;
        default: act_y = sat_t;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      act_reg       <= 2'd0;
      busy_reg      <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_y_reg     <= 16'sh0000;
      out_sat_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            acc_reg      <= bias_aligned;
            count_reg    <= '0;
            act_reg      <= act_sel;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b1;
            state_reg    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc_reg   <= acc_reg + ACC_W'(product);
            count_reg <= count_reg + 1'b1;
            if (count_reg == LAST_IDX) begin
              in_ready_reg <= 1'b0;
              state_reg    <= S_EXTRACT;
            end
          end
        end
        S_EXTRACT: begin
          out_y_reg     <= act_y;
          out_sat_reg   <= sat_flag;
          out_valid_reg <= 1'b1;
          state_reg     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          // Result held until taken; a coincident start is deliberately dropped.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_y     = out_y_reg;
  assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_q88_mac_neuron.sv
// Directed bench for q88_mac_neuron with hand-computed Q8.8 results.
module tb_q88_mac_neuron;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bias;
  logic [1:0]  act_sel;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_w;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic        out_sat;

  int total = 0;
  int bad   = 0;

  q88_mac_neuron dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias     (bias),
    .act_sel  (act_sel),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_w     (in_w),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_op(input logic [15:0] b, input logic [1:0] a);
    start   = 1'b1;
    bias    = b;
    act_sel = a;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] b, input logic [1:0] a,
                        input logic [15:0] x0, input logic [15:0] w0,
                        input logic [15:0] xr, input logic [15:0] wr,
                        input logic [15:0] exp_y, input logic exp_sat, output int lat);
    begin_op(b, a);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_x = (i == 0) ? x0 : xr;
      in_w = (i == 0) ? w0 : wr;
      tick();
    end
    in_valid = 1'b0;
    wait_out(tag, lat);
    check({tag, "_y"}, 32'(out_y), 32'(exp_y));
    check({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_done"}, {30'd0, busy, out_valid}, 32'd0);
    $display("op %s y=%h sat=%0d", tag, exp_y, exp_sat);
  endtask

  initial begin
    int lat;
    int sent;
    int guard;

    rst = 1'b1; start = 1'b0; bias = '0; act_sel = '0;
    in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_flags", {29'd0, busy, in_ready, out_valid}, 32'd0);
    check("rst_y", 32'(out_y), 32'h0000);
    check("rst_sat", 32'(out_sat), 32'd0);

    // Basic dot product and latency: out_valid one edge after the pair stream ends.
    run_op("basic", 16'h0040, 2'd0, 16'h0100, 16'h0080, 16'h0100, 16'h0080, 16'h0440, 1'b0, lat);
    check("latency", 32'(lat), 32'd1);

    run_op("relu_neg", 16'h0000, 2'd1, 16'hFF00, 16'h0100, 16'hFF00, 16'h0100, 16'h0000, 1'b0, lat);
    run_op("leaky_neg", 16'h0000, 2'd2, 16'hFF00, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 1'b0, lat);
    run_op("act3_none", 16'h0000, 2'd3, 16'hFF00, 16'h0100, 16'hFF00, 16'h0100, 16'hF800, 1'b0, lat);
    run_op("sat_pos", 16'h7FFF, 2'd0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, lat);
    run_op("sat_neg", 16'h0000, 2'd0, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 1'b1, lat);
    run_op("sat_neg_relu", 16'h0000, 2'd1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000, 1'b1, lat);
    run_op("sat_neg_leaky", 16'h0000, 2'd2, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'hF000, 1'b1, lat);
    run_op("edge_max", 16'h0000, 2'd0, 16'h7FFF, 16'h0100, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, lat);
    run_op("edge_max_p1", 16'h0001, 2'd0, 16'h7FFF, 16'h0100, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, lat);
    run_op("edge_min", 16'h0000, 2'd0, 16'h8000, 16'h0100, 16'h0000, 16'h0000, 16'h8000, 1'b0, lat);
    run_op("edge_min_m1", 16'hFFFF, 2'd0, 16'h8000, 16'h0100, 16'h0000, 16'h0000, 16'h8000, 1'b1, lat);
    run_op("trunc_floor", 16'h0000, 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, lat);
    run_op("leaky_small", 16'h0000, 2'd2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, lat);

    // Backpressure: random input gaps, then a stalled output.
    begin_op(16'h0040, 2'd0);
    in_x = 16'h0100; in_w = 16'h0080;
    sent = 0; guard = 0;
    while (sent < 8 && guard < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) sent++;
      tick();
      guard++;
    end
    check("bp_sent", 32'(sent), 32'd8);
    in_valid = 1'b1;
    check("bp_no_extra", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    wait_out("bp", lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_y", 32'(out_y), 32'h0440);
      check("bp_hold_v", 32'(out_valid), 32'd1);
      tick();
    end
    check("bp_sat", 32'(out_sat), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    check("bp_single", {30'd0, busy, out_valid}, 32'd0);
    $display("op bp y=0440 sent=%0d", sent);

    // Reset mid-accumulation discards the partial sum.
    begin_op(16'h0040, 2'd0);
    in_valid = 1'b1; in_x = 16'h0100; in_w = 16'h0080;
    tick(); tick(); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("abort_flags", {29'd0, busy, in_ready, out_valid}, 32'd0);
    rst = 1'b0;
    run_op("after_rst", 16'h0040, 2'd0, 16'h0100, 16'h0080, 16'h0100, 16'h0080, 16'h0440, 1'b0, lat);

    // start pulses outside IDLE are ignored.
    begin_op(16'h0040, 2'd0);
    in_valid = 1'b1; in_x = 16'h0100; in_w = 16'h0080;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    start = 1'b1; bias = 16'h1000;
    tick();
    start = 1'b0;
    check("ign_accum", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    wait_out("ign", lat);
    check("ign_y", 32'(out_y), 32'h0440);
    start = 1'b1; bias = 16'h2000;
    tick();
    check("ign_out_hold", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    check("ign_handshake", {30'd0, busy, out_valid}, 32'd0);
    tick();
    check("ign_idle", {30'd0, busy, in_ready}, 32'd0);
    $display("op ignore_start y=0440");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
